// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control unit: ALU_OP instruction classes,
// ALU operation selects and the FUNC7 patterns that qualify them.
package alu_ctrl_pkg;

  // Instruction class from the main control unit
  localparam logic [2:0] AluOpR     = 3'b000;
  localparam logic [2:0] AluOpLdSt  = 3'b001;
  localparam logic [2:0] AluOpBr    = 3'b010;
  localparam logic [2:0] AluOpI     = 3'b011;
  localparam logic [2:0] AluOpJmp   = 3'b100;
  localparam logic [2:0] AluOpLui   = 3'b101;
  localparam logic [2:0] AluOpAuipc = 3'b110;
  localparam logic [2:0] AluOpRsv   = 3'b111;

  // ALU operation selects
  localparam logic [4:0] AluAdd    = 5'b00000;
  localparam logic [4:0] AluSll    = 5'b00001;
  localparam logic [4:0] AluSlt    = 5'b00010;
  localparam logic [4:0] AluSltu   = 5'b00011;
  localparam logic [4:0] AluXor    = 5'b00100;
  localparam logic [4:0] AluSrl    = 5'b00101;
  localparam logic [4:0] AluOr     = 5'b00110;
  localparam logic [4:0] AluAnd    = 5'b00111;
  localparam logic [4:0] AluMul    = 5'b01000;
  localparam logic [4:0] AluMulh   = 5'b01001;
  localparam logic [4:0] AluMulhsu = 5'b01010;
  localparam logic [4:0] AluMulhu  = 5'b01011;
  localparam logic [4:0] AluDiv    = 5'b01100;
  localparam logic [4:0] AluDivu   = 5'b01101;
  localparam logic [4:0] AluRem    = 5'b01110;
  localparam logic [4:0] AluRemu   = 5'b01111;
  localparam logic [4:0] AluSub    = 5'b10000;
  localparam logic [4:0] AluSra    = 5'b10101;
  localparam logic [4:0] AluPassB  = 5'b11000;

  // FUNC7 qualifiers
  localparam logic [6:0] Func7Base   = 7'b0000000;
  localparam logic [6:0] Func7Alt    = 7'b0100000;
  localparam logic [6:0] Func7MulDiv = 7'b0000001;

  // FUNC3 codes that need FUNC7 qualification
  localparam logic [2:0] Func3AddSub = 3'b000;
  localparam logic [2:0] Func3Sll    = 3'b001;
  localparam logic [2:0] Func3Sr     = 3'b101;

  typedef struct packed {
    logic [4:0] alu_control;
    logic       illegal;
  } alu_dec_t;

  localparam alu_dec_t DecIllegal = '{alu_control: AluAdd, illegal: 1'b1};

  function automatic alu_dec_t dec_ok(input logic [4:0] op);
    dec_ok = '{alu_control: op, illegal: 1'b0};
  endfunction

endpackage

// File: rtl/alu_control_decode.sv
// Combinational decode of ALU_OP/FUNC3/FUNC7 into the next ALU operation
// select and illegal-encoding flag.
module alu_control_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] i_alu_op,
  input  logic [6:0] i_func7,
  input  logic [2:0] i_func3,
  output logic [4:0] o_alu_control,
  output logic       o_illegal
);

  alu_dec_t w_dec;

  always_comb begin
    w_dec = dec_ok(AluAdd);
    unique case (i_alu_op)
      AluOpR: begin
        if (i_func7 == Func7Base) begin
          w_dec = dec_ok({2'b00, i_func3});
        end else if (i_func7 == Func7MulDiv) begin
          w_dec = dec_ok({2'b01, i_func3});
        end else if (i_func7 == Func7Alt && i_func3 == Func3AddSub) begin
          w_dec = dec_ok(AluSub);
        end else if (i_func7 == Func7Alt && i_func3 == Func3Sr) begin
          w_dec = dec_ok(AluSra);
        end else begin
          w_dec = DecIllegal;
        end
      end
      AluOpI: begin
        // Only shifts carry meaning in FUNC7; immediates own those bits otherwise
        if (i_func3 == Func3Sll) begin
          w_dec = (i_func7 == Func7Base) ? dec_ok(AluSll) : DecIllegal;
        end else if (i_func3 == Func3Sr) begin
          if (i_func7 == Func7Base) begin
            w_dec = dec_ok(AluSrl);
          end else if (i_func7 == Func7Alt) begin
            w_dec = dec_ok(AluSra);
          end else begin
            w_dec = DecIllegal;
          end
        end else begin
          w_dec = dec_ok({2'b00, i_func3});
        end
      end
      AluOpBr: begin
        unique case (i_func3[2:1])
          2'b00:   w_dec = dec_ok(AluSub);
          2'b10:   w_dec = dec_ok(AluSlt);
          2'b11:   w_dec = dec_ok(AluSltu);
          default: w_dec = DecIllegal;
        endcase
      end
      AluOpLui:   w_dec = dec_ok(AluPassB);
      AluOpAuipc: w_dec = dec_ok(AluAdd);
      AluOpLdSt:  w_dec = dec_ok(AluAdd);
      AluOpJmp:   w_dec = dec_ok(AluAdd);
      AluOpRsv:   w_dec = DecIllegal;
      default:    w_dec = DecIllegal;
    endcase
  end

  assign o_alu_control = w_dec.alu_control;
  assign o_illegal     = w_dec.illegal;

endmodule

// File: rtl/alu_control_unit.sv
// ALU control unit: registered decode of the instruction class and function
// fields into the ALU operation select, forming part of the ID/EX boundary.
module alu_control_unit
  import alu_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic [6:0] FUNC7,
  input  logic [2:0] FUNC3,
  input  logic [2:0] ALU_OP,
  output logic [4:0] ALU_CONTROL,
  output logic       ILLEGAL
);

  logic [4:0] w_alu_control;
  logic       w_illegal;
  logic [4:0] r_alu_control;
  logic       r_illegal;

  alu_control_decode u_decode (
    .i_alu_op      (ALU_OP),
    .i_func7       (FUNC7),
    .i_func3       (FUNC3),
    .o_alu_control (w_alu_control),
    .o_illegal     (w_illegal)
  );

  // Synchronous active-low reset takes priority over the enable
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_alu_control <= AluAdd;
      r_illegal     <= 1'b0;
    end else if (EN) begin
      r_alu_control <= w_alu_control;
      r_illegal     <= w_illegal;
    end
  end

  assign ALU_CONTROL = r_alu_control;
  assign ILLEGAL     = r_illegal;

endmodule

// File: tb/tb_alu_control_unit.sv
// Self-checking bench for alu_control_unit: directed vector table, hand-written
// enable/reset sequences, and randomized traffic against a lookup-table model.
module tb_alu_control_unit;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [2:0] op;
  logic [4:0] alu_ctrl;
  logic       illegal;

  int checks;
  int errors;

  alu_control_unit dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .EN          (en),
    .FUNC7       (f7),
    .FUNC3       (f3),
    .ALU_OP      (op),
    .ALU_CONTROL (alu_ctrl),
    .ILLEGAL     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] ctrl;
    logic       ill;
    string      name;
  } vec_t;

  vec_t vecs[$];

  // Legal encodings only, keyed by {op, f7, f3}; value is the op select.
  // Anything absent from the table is illegal and decodes to ADD.
  bit [4:0] legal[bit [12:0]];

  task automatic add_legal(input int o, input int s7, input int s3, input int res);
    legal[{3'(o), 7'(s7), 3'(s3)}] = 5'(res);
  endtask

  task automatic build_model();
    for (int k = 0; k < 8; k++) begin
      add_legal(0, 0, k, k);            // ADD..AND
      add_legal(0, 1, k, 8 + k);        // MUL..REMU
    end
    add_legal(0, 32, 0, 16);            // SUB
    add_legal(0, 32, 5, 21);            // SRA
    add_legal(3, 0, 1, 1);              // SLLI
    add_legal(3, 0, 5, 5);              // SRLI
    add_legal(3, 32, 5, 21);            // SRAI
    for (int s7 = 0; s7 < 128; s7++) begin
      add_legal(3, s7, 0, 0);
      add_legal(3, s7, 2, 2);
      add_legal(3, s7, 3, 3);
      add_legal(3, s7, 4, 4);
      add_legal(3, s7, 6, 6);
      add_legal(3, s7, 7, 7);
      for (int s3 = 0; s3 < 8; s3++) begin
        add_legal(1, s7, s3, 0);        // load/store address
        add_legal(4, s7, s3, 0);        // jump target
        add_legal(5, s7, s3, 24);       // LUI pass-B
        add_legal(6, s7, s3, 0);        // AUIPC
      end
      add_legal(2, s7, 0, 16);          // BEQ
      add_legal(2, s7, 1, 16);          // BNE
      add_legal(2, s7, 4, 2);           // BLT
      add_legal(2, s7, 5, 2);           // BGE
      add_legal(2, s7, 6, 3);           // BLTU
      add_legal(2, s7, 7, 3);           // BGEU
    end
  endtask

  function automatic logic [5:0] model(input logic [2:0] o, input logic [6:0] s7,
                                       input logic [2:0] s3);
    bit [12:0] key;
    key = {o, s7, s3};
    if (legal.exists(key)) model = {legal[key], 1'b0};
    else model = {5'd0, 1'b1};
  endfunction

  task automatic check(input string name, input logic [4:0] exp_c, input logic exp_i);
    checks++;
    if (alu_ctrl !== exp_c || illegal !== exp_i) begin
      errors++;
      $display("FAIL %s: got ctrl=%05b ill=%b, expected ctrl=%05b ill=%b (op=%03b f7=%07b f3=%03b)",
               name, alu_ctrl, illegal, exp_c, exp_i, op, f7, f3);
    end
  endtask

  // Drive at the negedge, let one rising edge pass, return at the next negedge
  task automatic step(input logic r, input logic e, input logic [2:0] o,
                      input logic [6:0] s7, input logic [2:0] s3);
    rst_n = r;
    en    = e;
    op    = o;
    f7    = s7;
    f3    = s3;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic vec(input int o, input int s7, input int s3, input int c, input int i,
                     input string name);
    vec_t v;
    v.op = 3'(o); v.f7 = 7'(s7); v.f3 = 3'(s3); v.ctrl = 5'(c); v.ill = 1'(i); v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    logic [4:0] exp_c;
    logic       exp_i;
    logic [5:0] m;
    checks = 0;
    errors = 0;
    rst_n = 1'b0; en = 1'b0; op = 3'd0; f7 = 7'd0; f3 = 3'd0;
    build_model();

    for (int k = 0; k < 8; k++) begin
      vec(0, 0, k, k, 0, "r_base");
      vec(0, 1, k, 8 + k, 0, "r_muldiv");
    end
    vec(0, 32, 5, 21, 0, "r_sra");
    vec(0, 32, 7, 0, 1, "r_alt_and_illegal");
    vec(0, 32, 0, 16, 0, "r_sub");
    vec(0, 5, 0, 0, 1, "r_bad_f7");
    vec(3, 0, 0, 0, 0, "i_addi");
    vec(3, 0, 2, 2, 0, "i_slti");
    vec(3, 0, 3, 3, 0, "i_sltiu");
    vec(3, 0, 4, 4, 0, "i_xori");
    vec(3, 0, 6, 6, 0, "i_ori");
    vec(3, 0, 7, 7, 0, "i_andi");
    vec(3, 0, 1, 1, 0, "i_slli");
    vec(3, 0, 5, 5, 0, "i_srli");
    vec(3, 32, 5, 21, 0, "i_srai");
    vec(3, 32, 0, 0, 0, "i_addi_f7_ignored");
    vec(3, 32, 1, 0, 1, "i_slli_bad_f7");
    vec(3, 1, 5, 0, 1, "i_sr_bad_f7");
    vec(5, 85, 3, 24, 0, "lui");
    vec(6, 32, 7, 0, 0, "auipc");
    vec(1, 0, 2, 0, 0, "ldst");
    vec(4, 0, 0, 0, 0, "jump");
    vec(2, 0, 1, 16, 0, "br_bne");
    vec(2, 0, 5, 2, 0, "br_bge");
    vec(2, 0, 7, 3, 0, "br_bgeu");
    vec(2, 0, 3, 0, 1, "br_illegal");
    vec(7, 0, 0, 0, 1, "reserved");

    // Reset, then first-transaction latency with no combinational path
    @(negedge clk);
    step(1'b0, 1'b1, 3'd0, 7'h20, 3'd0);
    check("reset_state", 5'd0, 1'b0);
    rst_n = 1'b1; en = 1'b1; op = 3'd0; f7 = 7'h20; f3 = 3'd0;
    #1;
    check("no_comb_path", 5'd0, 1'b0);
    @(posedge clk);
    #1;
    check("sub_one_edge", 5'b10000, 1'b0);
    @(negedge clk);

    foreach (vecs[k]) begin
      step(1'b1, 1'b1, vecs[k].op, vecs[k].f7, vecs[k].f3);
      check(vecs[k].name, vecs[k].ctrl, vecs[k].ill);
    end

    // Enable hold and reset-over-enable sequences
    step(1'b1, 1'b1, 3'd0, 7'h00, 3'd0);
    check("hold_setup_add", 5'd0, 1'b0);
    step(1'b1, 1'b0, 3'd0, 7'h20, 3'd0);
    check("hold_ignores_sub", 5'd0, 1'b0);
    step(1'b1, 1'b1, 3'd7, 7'h00, 3'd0);
    check("hold_setup_illegal", 5'd0, 1'b1);
    step(1'b1, 1'b0, 3'd5, 7'h00, 3'd0);
    check("hold_keeps_illegal", 5'd0, 1'b1);
    step(1'b1, 1'b1, 3'd5, 7'h00, 3'd0);
    check("setup_passb", 5'b11000, 1'b0);
    step(1'b0, 1'b0, 3'd0, 7'h20, 3'd0);
    check("reset_over_en", 5'd0, 1'b0);
    step(1'b1, 1'b1, 3'd7, 7'h00, 3'd0);
    step(1'b0, 1'b0, 3'd7, 7'h00, 3'd0);
    check("reset_clears_illegal", 5'd0, 1'b0);

    // Randomized traffic against the lookup model
    exp_c = 5'd0;
    exp_i = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic       r_r, r_e;
      logic [2:0] r_o, r_s3;
      logic [6:0] r_s7;
      r_r  = ($urandom_range(0, 19) != 0);
      r_e  = ($urandom_range(0, 3) != 0);
      r_o  = 3'($urandom_range(0, 7));
      r_s3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       r_s7 = 7'h00;
        1:       r_s7 = 7'h01;
        2:       r_s7 = 7'h20;
        default: r_s7 = 7'($urandom_range(0, 127));
      endcase
      if (!r_r) begin
        exp_c = 5'd0;
        exp_i = 1'b0;
      end else if (r_e) begin
        m = model(r_o, r_s7, r_s3);
        exp_c = m[5:1];
        exp_i = m[0];
      end
      step(r_r, r_e, r_o, r_s7, r_s3);
      check("random", exp_c, exp_i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
